dac_thermo_loader: RTL
======================

// Module: dac_thermo_loader
// PURPOSE
//  Upstream sequencer for the 128-cell current-steering DAC daisychain.
//  Accepts a binary target code over a valid/ready handshake and converts it to a thermometer pattern.
//  Serially shifts the pattern into the chain with datum/shift strobes.
//  Then issues a single transfer (dir=1) that copies the chain into the cell state register.
//  Drives the chain's datum/shift/transfer/dir controls directly; one code = one full DAC update.
// PARAMETERS
//  N_CELLS  128                      number of DAC cells / daisychain length
//  CODE_W   $clog2(N_CELLS+1) (=8)   width of the code input; legal codes 0..N_CELLS
// PORTS
//  clk         in   1       clock
//  rst_n       in   1       reset, synchronous, active-low
//  code_valid  in   1       code offered
//  code_ready  out  1       loader idle, accepts code this cycle
//  code        in   CODE_W  number of cells to turn on (thermometer count)
//  datum       out  1       serial data to chain (registered)
//  shift       out  1       shift strobe to chain (registered)
//  transfer    out  1       transfer strobe to chain (registered)
//  dir         out  1       transfer direction, 1 = chain->state (registered)
//  busy        out  1       high in SHIFT/XFER
//  done        out  1       1-cycle pulse, coincident with transfer
//  sat         out  1       1-cycle pulse on acceptance of a code > N_CELLS
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge):
//    - FSM forced to IDLE; bit counter cleared.
//    - datum/shift/transfer/dir/done/sat/busy all 0.
//    - code_ready=1 from the first cycle after reset.
//  - code_ready = (state==IDLE), combinational from the state register.
//  - Accept = code_valid & code_ready.
//    - Code latched, clamped: code > N_CELLS -> N_CELLS.
//    - sat pulses in the cycle after accept.
//  - FSM:
//    - IDLE -> SHIFT on accept.
//    - SHIFT -> XFER after N_CELLS shift cycles.
//    - XFER -> IDLE after 1 cycle.
//  - Timing, accept at edge t:
//    - shift=1 for cycles t+1..t+N_CELLS.
//    - transfer=1, dir=1, done=1 at cycle t+N_CELLS+1.
//    - code_ready=1 again at t+N_CELLS+2.
//    - Total N_CELLS+2 cycles per update.
//  - Shift index i = 0..N_CELLS-1 counts up.
//    - datum = (i >= N_CELLS - code_latched).
//    - Bit shifted first lands in cell N_CELLS-1, so cells [code-1:0] end up ON.
//  - shift and transfer are never high in the same cycle.
//  - datum=0 whenever shift=0.
//  - dir=1 only while transfer=1, else 0. The loader never issues a dir=0 readback transfer.
//  - code=0: shifts N_CELLS zeros then transfers (all cells off).
//  - code=N_CELLS: all ones.
//  - code_valid held high with new data while busy: ignored. Not queued, not sticky.
//  - Reset mid-SHIFT/XFER: abort immediately, outputs to reset values, no transfer issued.
//    - DAC state untouched; the chain holds partial data.
//  - Counter width $clog2(N_CELLS); no wrap beyond N_CELLS-1.
// CONFIGURATION
//  DAC_LOADER_SKIP_EN (define): loader keeps last_code plus a last_valid flag.
//    - Both are cleared by reset and set on each completed XFER.
//    - Accepted (clamped) code == last_code with last_valid=1:
//      - No shift, no transfer.
//      - done pulses at t+1; code_ready back at t+2.
//    - Reset mid-operation leaves last_valid=0.
//  Undefined: every accepted code performs a full shift + transfer, and no last_code storage is built.
// TESTING
//  T1 Reset:
//     - rst_n=0 for 3 cycles -> all outputs 0, code_ready=1 at the first cycle after release.
//  T2 Code=5 accepted at t:
//     - shift=1 for 128 cycles.
//     - datum=0 for i=0..122 and 1 for i=123..127.
//     - transfer=dir=done=1 at t+129; code_ready=1 at t+130.
//  T3 Code=200:
//     - sat=1 at t+1.
//     - 128 ones shifted; chain model final state all ones after transfer.
//  T4 code_valid held high with codes 0 then 128:
//     - second accepted exactly at t+130.
//     - mid-shift code changes ignored.
//     - final DAC model state = all ones.
//  T5 Reset asserted at shift index 40:
//     - next cycle shift=0, transfer never pulses.
//     - code_ready=1 after release.
//  T6 (DAC_LOADER_SKIP_EN) Codes 7, 7, 8:
//     - second load: done at t+1 and zero shift cycles.
//     - third load: full 130-cycle sequence.

Source files
------------

// File: rtl/dac_thermo_loader.sv
// rtl/dac_thermo_loader.sv - binary code to thermometer serial loader for the DAC daisychain
//
// Ports:
//   clk, rst_n           clock; synchronous active-low reset
//   code_valid/ready     code handshake (ready = FSM idle)
//   code [CODE_W-1:0]    number of cells to turn on, clamped to N_CELLS
//   datum, shift         serial data and shift strobe to the chain
//   transfer, dir        transfer strobe and direction (1 = chain -> cell state)
//   busy                 high while shifting or transferring
//   done                 one-cycle pulse marking the end of an update
//   sat                  one-cycle pulse after accepting a code above N_CELLS
//
// Optional feature macro: DAC_LOADER_SKIP_EN
//   When defined, a code equal to the last completed load is acknowledged with
//   done only, without touching the chain.
module dac_thermo_loader #(
    parameter int N_CELLS = 128,
    parameter int CODE_W  = $clog2(N_CELLS + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              code_valid,
    output logic              code_ready,
    input  logic [CODE_W-1:0] code,
    output logic              datum,
    output logic              shift,
    output logic              transfer,
    output logic              dir,
    output logic              busy,
    output logic              done,
    output logic              sat
);

    localparam int                CNT_W    = $clog2(N_CELLS);
    localparam logic [CODE_W-1:0] N_CODE   = CODE_W'(N_CELLS);
    localparam logic [CNT_W-1:0]  LAST_IDX = CNT_W'(N_CELLS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        XFER  = 2'd2
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CODE_W-1:0] code_latched;

    logic              accept;
    logic              skip_hit;
    logic [CODE_W-1:0] code_clamped;
    logic [CODE_W-1:0] thresh_in;
    logic [CODE_W-1:0] thresh;
    logic [CODE_W-1:0] idx_next;

    assign code_ready   = (state == IDLE);
    assign accept       = code_valid & code_ready;
    assign code_clamped = (code > N_CODE) ? N_CODE : code;

    // The first bit shifted ends up in the highest cell, so a cell index i
    // receives a one once the shift index reaches N_CELLS - code.
    assign thresh_in    = N_CODE - code_clamped;
    assign thresh       = N_CODE - code_latched;
    assign idx_next     = CODE_W'(cnt) + CODE_W'(1);

`ifdef DAC_LOADER_SKIP_EN
    logic [CODE_W-1:0] last_code;
    logic              last_valid;

    assign skip_hit = last_valid && (code_clamped == last_code);
`else
    assign skip_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            code_latched <= '0;
            datum        <= 1'b0;
            shift        <= 1'b0;
            transfer     <= 1'b0;
            dir          <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            sat          <= 1'b0;
`ifdef DAC_LOADER_SKIP_EN
            last_code    <= '0;
            last_valid   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            sat  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        code_latched <= code_clamped;
                        sat          <= (code > N_CODE);
                        busy         <= 1'b1;
                        cnt          <= '0;
                        if (skip_hit) begin
                            // Chain already holds this pattern: acknowledge only.
                            state <= XFER;
                            done  <= 1'b1;
                        end else begin
                            state <= SHIFT;
                            shift <= 1'b1;
                            datum <= (thresh_in == '0);
                        end
                    end
                end
                SHIFT: begin
                    if (cnt == LAST_IDX) begin
                        state    <= XFER;
                        shift    <= 1'b0;
                        datum    <= 1'b0;
                        transfer <= 1'b1;
                        dir      <= 1'b1;
                        done     <= 1'b1;
                    end else begin
                        cnt   <= cnt + CNT_W'(1);
                        datum <= (idx_next >= thresh);
                    end
                end
                XFER: begin
                    state    <= IDLE;
                    transfer <= 1'b0;
                    dir      <= 1'b0;
                    busy     <= 1'b0;
                    cnt      <= '0;
`ifdef DAC_LOADER_SKIP_EN
                    last_code  <= code_latched;
                    last_valid <= 1'b1;
`endif
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
